// File: rtl/scope_pkg.sv
// scope_pkg: shared constants and types for the trigger capture slice.
// Imported by trigger_capture; capture_ram is type-agnostic.
package scope_pkg;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 256;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_t;

  typedef enum logic {
    RISING  = 1'b0,
    FALLING = 1'b1
  } slope_t;

endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample store, one write port and a
// registered read port, written to infer block RAM.
module capture_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: level/slope trigger with pre-trigger circular capture.
// Define TRIG_HYST_EN to require a hysteresis excursion before triggering.
module trigger_capture #(
  parameter int DATA_W = scope_pkg::DATA_W,
  parameter int DEPTH  = scope_pkg::DEPTH,
`ifdef TRIG_HYST_EN
  parameter int HYST   = 16,
`endif
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  import scope_pkg::*;

  cap_state_t        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] post_init;
  logic [ADDR_W-1:0] win_start;
  logic [ADDR_W-1:0] rd_phys;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              force_pend;
  logic              active;
  logic              accept;
  logic              rd_en;
  logic              rise;
  logic              fall;
  logic              hit;

  assign active = (state == PREFILL)
               || (state == WAIT_TRIG)
               || (state == POST);
  assign accept = sample_valid && !arm && active;
  assign rd_en = rd_req && (state == DONE);
  assign rd_phys = win_start + rd_addr;
  assign post_init = ADDR_W'(DEPTH - 1) - pretrig;

`ifdef TRIG_HYST_EN
  logic [DATA_W:0]   hi_sum;
  logic [DATA_W-1:0] lo_thr;
  logic [DATA_W-1:0] hi_thr;
  logic              seen_lo;
  logic              seen_hi;

  assign hi_sum = {1'b0, trig_level} + (DATA_W+1)'(HYST);
  assign lo_thr = (trig_level >= DATA_W'(HYST))
                ? trig_level - DATA_W'(HYST) : '0;
  assign hi_thr = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];

  // Re-arm flags only look at samples before the current one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seen_lo <= 1'b0;
      seen_hi <= 1'b0;
    end else if (arm) begin
      seen_lo <= 1'b0;
      seen_hi <= 1'b0;
    end else if (accept) begin
      seen_lo <= seen_lo || (sample_data < lo_thr);
      seen_hi <= seen_hi || (sample_data > hi_thr);
    end
  end

  assign rise = seen_lo && prev_valid
             && (prev < trig_level)
             && (sample_data >= trig_level);
  assign fall = seen_hi && prev_valid
             && (prev > trig_level)
             && (sample_data <= trig_level);
`else
  assign rise = prev_valid
             && (prev < trig_level)
             && (sample_data >= trig_level);
  assign fall = prev_valid
             && (prev > trig_level)
             && (sample_data <= trig_level);
`endif

  assign hit = (slope_t'(trig_slope) == FALLING) ? fall : rise;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      win_start  <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      force_pend <= 1'b0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (arm) begin
        state      <= (pretrig == '0) ? WAIT_TRIG : PREFILL;
        pre_cnt    <= '0;
        prev_valid <= 1'b0;
        force_pend <= 1'b0;
        busy       <= 1'b1;
        triggered  <= 1'b0;
        done       <= 1'b0;
      end else begin
        if (accept) begin
          wr_ptr     <= wr_ptr + 1'b1;
          prev       <= sample_data;
          prev_valid <= 1'b1;
        end
        unique case (state)
          PREFILL: begin
            if (accept) begin
              pre_cnt <= pre_cnt + 1'b1;
              if (ADDR_W'(pre_cnt + 1'b1) == pretrig)
                state <= WAIT_TRIG;
            end
          end
          WAIT_TRIG: begin
            if (accept && (hit || force_pend || force_trig)) begin
              win_start  <= wr_ptr - pretrig;
              post_cnt   <= post_init;
              triggered  <= 1'b1;
              force_pend <= 1'b0;
              if (post_init == '0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= POST;
              end
            end else if (force_trig) begin
              force_pend <= 1'b1;
            end
          end
          POST: begin
            if (accept) begin
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == ADDR_W'(1)) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .we      (accept),
    .wr_addr (wr_ptr),
    .wr_data (sample_data),
    .re      (rd_en),
    .rd_addr (rd_phys),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: directed + random captures against a sample-list
// model of the capture window.
module tb_trigger_capture;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample_data = '0;
  logic        arm = 1'b0;
  logic        force_trig = 1'b0;
  logic [11:0] trig_level = '0;
  logic        trig_slope = 1'b0;
  logic [7:0]  pretrig = '0;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        triggered;
  logic        done;

  trigger_capture dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .arm          (arm),
    .force_trig   (force_trig),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .pretrig      (pretrig),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .triggered    (triggered),
    .done         (done)
  );

  always #10 clock = ~clock;

  localparam int N = 256;

  int n_chk = 0;
  int n_fail = 0;

  // Model: every sample accepted since arm, and index of the trigger.
  int hist[$];
  int trig_idx = -1;
  int cap_pre = 0;
  int m_level = 0;
  bit m_slope = 1'b0;
  bit m_active = 1'b0;
  bit m_fp = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_done();
    return trig_idx >= 0 && hist.size() >= trig_idx + N - cap_pre;
  endfunction

  function automatic bit crossing(int k);
    int p, c;
    bit ok;
    if (k == 0) return 1'b0;
    p = hist[k-1];
    c = hist[k];
    ok = 1'b1;
`ifdef TRIG_HYST_EN
    ok = 1'b0;
    for (int j = 0; j < k; j++) begin
      if (!m_slope && hist[j] < m_level - 16) ok = 1'b1;
      if (m_slope && hist[j] > m_level + 16) ok = 1'b1;
    end
`endif
    if (!m_slope) return ok && p < m_level && c >= m_level;
    return ok && p > m_level && c <= m_level;
  endfunction

  function automatic int gen(int mode, int i);
    case (mode)
      0: return (i * 16 > 4095) ? 4095 : i * 16;
      1: return (4095 - 13 * i < 0) ? 0 : 4095 - 13 * i;
      3: return (992 + 8 * i > 4095) ? 4095 : 992 + 8 * i;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input int v, input bit f);
    int k;
    sample_valid = 1'b1;
    sample_data = 12'(v);
    force_trig = f;
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    force_trig = 1'b0;
    if (m_active && !m_done()) begin
      hist.push_back(v);
      k = hist.size() - 1;
      if (trig_idx < 0 && k >= cap_pre
          && (f || m_fp || crossing(k))) begin
        trig_idx = k;
        m_fp = 1'b0;
      end
    end
    check("triggered", triggered, trig_idx >= 0);
    check("done", done, m_done());
    check("busy", busy, m_active && !m_done());
    idle($urandom_range(0, 2));
  endtask

  task automatic force_only();
    force_trig = 1'b1;
    @(posedge clock);
    #1;
    force_trig = 1'b0;
    if (m_active && !m_done() && trig_idx < 0
        && hist.size() >= cap_pre)
      m_fp = 1'b1;
  endtask

  task automatic arm_cap(input int pre, input int lvl, input bit slp,
                         input bit with_s, input int sv);
    pretrig = 8'(pre);
    trig_level = 12'(lvl);
    trig_slope = slp;
    arm = 1'b1;
    sample_valid = with_s;
    sample_data = 12'(sv);
    @(posedge clock);
    #1;
    arm = 1'b0;
    sample_valid = 1'b0;
    hist.delete();
    trig_idx = -1;
    m_fp = 1'b0;
    m_active = 1'b1;
    cap_pre = pre;
    m_level = lvl;
    m_slope = slp;
    check("arm_busy", busy, 1);
    check("arm_triggered", triggered, 0);
    check("arm_done", done, 0);
  endtask

  task automatic run_capture(input int mode, input int i0);
    int i;
    i = i0;
    while (!m_done() && i < i0 + 1500) begin
      send(gen(mode, i), 1'b0);
      i++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic read_const(input int a, input int exp);
    rd_req = 1'b1;
    rd_addr = 8'(a);
    @(posedge clock);
    #1;
    rd_req = 1'b0;
    check("rd_valid_const", rd_valid, 1);
    check("rd_data_const", rd_data, exp);
  endtask

  task automatic read_sweep(input int n, input bit rnd);
    int a;
    if (m_done()) begin
      for (int j = 0; j < n; j++) begin
        a = rnd ? int'($urandom_range(0, N - 1)) : j;
        rd_req = 1'b1;
        rd_addr = 8'(a);
        @(posedge clock);
        #1;
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, hist[trig_idx - cap_pre + a]);
      end
    end
    rd_req = 1'b0;
    @(posedge clock);
    #1;
    check("rd_valid_drop", rd_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_triggered"}, triggered, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int pre;
    bit exp_trig;

    #25;
    check_reset_outputs("reset");
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle(1);
    rd_req = 1'b1;
    @(posedge clock);
    #1;
    rd_req = 1'b0;
    check("rd_in_idle", rd_valid, 0);

    // Rising ramp, pretrig 64.
    arm_cap(64, 'h400, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) send(gen(0, i), 1'b0);
    rd_req = 1'b1;
    @(posedge clock);
    #1;
    rd_req = 1'b0;
    check("rd_in_prefill", rd_valid, 0);
    run_capture(0, 10);
    read_const(64, 'h400);
    read_const(0, 'h000);
    read_sweep(N, 1'b0);

    // Falling ramp from 0xFFF, level 0x800, pretrig 100.
    arm_cap(100, 'h800, 1'b1, 1'b0, 0);
    run_capture(1, 0);
    read_const(100, 'h7F9);
    read_sweep(32, 1'b1);

    // pretrig 0 with force on the first accepted sample.
    arm_cap(0, 'hFFF, 1'b0, 1'b0, 0);
    first = int'($urandom_range(0, 4095));
    send(first, 1'b1);
    run_capture(2, 1);
    read_const(0, first);
    read_sweep(16, 1'b1);

    // Back-to-back capture, armed from DONE.
    arm_cap(200, 'h800, 1'b0, 1'b0, 0);
    run_capture(2, 0);
    read_sweep(N, 1'b0);

    // Random captures, including pretrig 255 and a lone force pulse.
    for (int r = 0; r < 4; r++) begin
      pre = (r == 0) ? 255 : int'($urandom_range(1, 254));
      if (r == 1) begin
        arm_cap(pre, 'hFFF, 1'b0, 1'b0, 0);
        for (int i = 0; i < pre + 5; i++) send(gen(2, i), 1'b0);
        force_only();
        idle(2);
      end else begin
        arm_cap(pre, int'($urandom_range('h200, 'hE00)),
                1'($urandom_range(0, 1)), 1'b0, 0);
      end
      run_capture(2, 0);
      read_const(pre, hist[trig_idx]);
      read_sweep(24, 1'b1);
    end

    // arm coincident with a sample: that sample must be dropped.
    arm_cap(16, 'h600, 1'b0, 1'b1, 'h5A5);
    run_capture(2, 0);
    read_sweep(N, 1'b0);

    // Reset pulsed during POST.
    arm_cap(16, 'h600, 1'b0, 1'b0, 0);
    for (int i = 0; i < 1500; i++) begin
      if (trig_idx >= 0 && hist.size() >= trig_idx + 20) break;
      send(gen(2, i), 1'b0);
    end
    check("post_busy", busy, 1);
    reset = 1'b0;
    #3;
    check_reset_outputs("midreset");
    hist.delete();
    trig_idx = -1;
    m_active = 1'b0;
    m_fp = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    rd_req = 1'b1;
    @(posedge clock);
    #1;
    rd_req = 1'b0;
    check("rd_after_reset", rd_valid, 0);
    idle(1);
    check("rd_after_reset2", rd_valid, 0);

    // Noise around the level, then a clean rise.
    arm_cap(8, 'h400, 1'b0, 1'b0, 0);
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 1) send('h400 + int'($urandom_range(0, 8)), 1'b0);
      else send('h3F8 + int'($urandom_range(0, 7)), 1'b0);
    end
`ifdef TRIG_HYST_EN
    exp_trig = 1'b0;
`else
    exp_trig = 1'b1;
`endif
    check("hyst_gate", triggered, exp_trig);
    send('h3E0, 1'b0);
    run_capture(3, 0);
    read_sweep(32, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Sits directly downstream of the ADC sampling stage.
- Consumes the 12-bit sample and its one-cycle refresh strobe, which pulses once every 537 clocks at 50 MHz.
- Performs level/slope triggering with a programmable pre-trigger depth and stores one capture window in a circular buffer.
- Exposes the captured window to the display/readout logic as a random-access port, indexed oldest-first.

Parameters:
- DATA_W, 12, sample width.
- DEPTH, 256, capture buffer length in samples; must be a power of two.
- ADDR_W, $clog2(DEPTH), buffer index width. Derived; not to be overridden.
- HYST, 16, hysteresis in LSBs. Used only when TRIG_HYST_EN is defined.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle strobe: new sample available
- sample_data  in  DATA_W  unsigned ADC code
- arm  in  1  one-cycle pulse: start a new capture
- force_trig  in  1  one-cycle pulse: trigger immediately while waiting
- trig_level  in  DATA_W  trigger threshold, unsigned
- trig_slope  in  1  0 = rising, 1 = falling
- pretrig  in  ADDR_W  number of samples kept before the trigger sample
- rd_req  in  1  read request
- rd_addr  in  ADDR_W  logical index; 0 = oldest sample in the window
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data is valid
- busy  out  1  capture in progress (PREFILL, WAIT_TRIG or POST)
- triggered  out  1  trigger has occurred in the current capture
- done  out  1  window complete and readable

Behaviour:
- Reset: state = IDLE; wr_ptr = 0; all counters = 0; prev_valid = 0.
- Reset values of outputs: rd_data = 0, rd_valid = 0, busy = 0, triggered = 0, done = 0.
- Reset asserted mid-capture aborts to IDLE. Buffer contents are don't-care after reset.
- States:
  - IDLE: waits for arm.
  - PREFILL: writes each valid sample, wr_ptr++, pre_cnt++. Leaves for WAIT_TRIG when pre_cnt == pretrig. With pretrig = 0, arm goes directly to WAIT_TRIG.
  - WAIT_TRIG: writes every valid sample. On trigger: trig_addr = wr_ptr of that sample; post_cnt = DEPTH-1-pretrig; triggered = 1; go to POST (to DONE if post_cnt = 0).
  - POST: writes each valid sample, post_cnt--. On the write that brings post_cnt to 0, go to DONE; done = 1 from the next cycle.
  - DONE: holds. Buffer is frozen.
- arm is accepted in any state. It restarts the capture (clears triggered, done, pre_cnt and prev_valid) and has priority over a sample_valid in the same cycle; that sample is dropped.
- Rising trigger: prev_valid && prev < trig_level && cur >= trig_level.
- Falling trigger: prev_valid && prev > trig_level && cur <= trig_level.
- prev/prev_valid update on every accepted sample, so the first sample after arm can never trigger.
- force_trig in WAIT_TRIG: the sample in the same cycle (or the next valid sample) becomes the trigger sample. force_trig is ignored in all other states.
- Window start = (trig_addr - pretrig) mod DEPTH.
- Read mapping: physical address = (start + rd_addr) mod DEPTH, with wrap-around.
- Read timing: rd_req is honoured only in DONE. rd_valid pulses exactly 1 cycle after rd_req; reads may be back-to-back, one per cycle. In all other states rd_valid stays 0.
- The trigger sample always appears at logical index pretrig.
- All comparisons are unsigned, full DATA_W wide.

Optional Feature:
- Macro: TRIG_HYST_EN.
- Defined: a rising trigger additionally requires a prior accepted sample below trig_level-HYST since arm. A falling trigger requires one above trig_level+HYST. Bounds saturate at 0 and 2^DATA_W-1. The re-arm flag is cleared on arm.
- Undefined: plain crossing detection; HYST is unused.

Decomposition:
- Package scope_pkg:
  - DATA_W and DEPTH constants.
  - cap_state_t enum: IDLE, PREFILL, WAIT_TRIG, POST, DONE.
  - slope_t: RISING = 0, FALLING = 1.
- Sub-module capture_ram: simple dual-port, one write port, registered read port, DEPTH x DATA_W, inferable as block RAM.
- FSM and address arithmetic live in trigger_capture.

Test Plan:
- Ramp 0,16,32,… with level = 0x400, rising, pretrig = 64, arm -> triggered on the sample 0x400. After 191 further samples, done = 1. rd_addr 64 returns 0x400; rd_addr 0 returns 0x000.
- Falling trigger: descending ramp from 0xFFF with level = 0x800 -> trigger sample is the first value <= 0x800. It appears at index pretrig.
- pretrig = 0 plus force_trig on the first accepted sample -> no PREFILL; index 0 holds that sample; done after 256 samples.
- Wrap: run two captures back to back without reset (arm in DONE) -> the second window reads correctly across the physical address 255→0 boundary. triggered/done clear on arm.
- arm coincident with sample_valid, and reset pulsed during POST -> the sample is not written; reset returns all outputs to 0 and rd_valid stays 0 for an rd_req issued afterwards.
- TRIG_HYST_EN defined: signal noise ±8 around 0x400, then a clean rise -> no trigger until a sample < 0x3F0 has been seen. Without the macro, the first crossing triggers.
